md_unit_param: RTL
==================

Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It owns the architectural HI/LO registers and runs multi-cycle mult/div/madd/msub operations.
- It reports start/busy so the hazard controller can stall MDU-dependent instructions in D.
- Compared with the current MDU it adds configurable width and latencies, multiply-accumulate, a cancel input for exception flush, and defined divide-by-zero/overflow results.

Parameters:
- WIDTH, 32, operand and HI/LO width (must be >= 2)
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- operand1  in  WIDTH  rs value, already forwarded
- operand2  in  WIDTH  rt value, already forwarded
- operation  in  4  MDUOP code from md_pkg
- cancel  in  1  instruction in E is being flushed; suppresses the operation this cycle
- HI  out  WIDTH  architectural HI register
- LO  out  WIDTH  architectural LO register
- start  out  1  combinational; a multi-cycle operation is accepted this cycle
- busy  out  1  registered; a multi-cycle operation is in flight

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending results=0. Reset during an operation aborts it and commits nothing.
- Operation classes:
  - multi-cycle: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
  - single-cycle: MTHI, MTLO
  - NOOP and undefined codes: no effect
- start = multi-cycle op && !busy && !cancel. Purely combinational; no dependence on clock edge.
- On the edge ending a start cycle:
  - operands are latched, result computed into pending_hi/pending_lo
  - counter = N-1, where N = MUL_CYCLES or DIV_CYCLES; busy=1
  - later operand changes have no effect on the result
- While busy: counter decrements each edge. On the edge where counter==0 and busy==1, HI/LO <= pending values and busy <= 0.
- Latency: start in cycle t → busy high in cycles t+1..t+N → new HI/LO visible from cycle t+N+1, with busy=0 in that cycle.
- Ops presented while busy are ignored, including MTHI/MTLO; the hazard unit guarantees none arrive. A new start is allowed in cycle t+N+1 (back-to-back).
- MTHI/MTLO (!busy && !cancel): HI or LO <= operand1 on the next edge. No busy, start stays 0.
- cancel=1: the operation in that cycle has no effect of any kind. cancel while busy does not abort the in-flight operation.
- Arithmetic:
  - MULT: {HI,LO} = signed operand1*operand2, full 2*WIDTH product
  - MULTU: {HI,LO} = unsigned operand1*operand2
  - MADD/MSUB: {HI,LO} ± signed product, modulo 2^(2*WIDTH)
  - MADDU/MSUBU: same, with unsigned product
  - The accumulate base is HI/LO as they stand at the start edge.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend
  - DIVU: unsigned quotient and remainder
- Boundaries:
  - divisor 0 (DIV/DIVU): HI/LO unchanged after the full DIV_CYCLES busy period
  - DIV of -2^(WIDTH-1) by -1: LO = -2^(WIDTH-1), HI = 0
  - MUL_CYCLES=1: busy high exactly one cycle

Decomposition:
- md_pkg holds:
  - MDUOP_SIZE=4
  - MDUOP_NOOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10
  - helper constant for the counter width, $clog2 of max(MUL_CYCLES, DIV_CYCLES)
- One sub-module, md_arith: a combinational datapath (operands, op, current HI/LO → pending_hi/pending_lo, div_by_zero). The top holds the counter, busy logic and HI/LO registers.

Test Plan:
- Reset, then MULT 0xFFFFFFFE × 3 (WIDTH=32): start=1 in t; busy high t+1..t+5; from t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- DIVU 7/2, then DIV −7/2: after 10 busy cycles HI=1, LO=3; then HI=0xFFFFFFFF, LO=0xFFFFFFFD. Also DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1: start=0 and busy=0 for both MT ops; after 5 cycles HI=1, LO=0. Then MSUB 1×2 → HI=0, LO=0xFFFFFFFE.
- DIV 5/0 with HI=0xAA, LO=0xBB preset: busy high for 10 cycles; HI/LO remain 0xAA/0xBB.
- cancel=1 with MULT: start=0, busy stays 0, HI/LO unchanged. Then cancel=1 on cycle t+2 of an in-flight MULT: result still commits at t+6.
- reset pulsed low mid-DIV, then back-to-back MULT 2×3 → MULT 4×5 at t and t+6: after reset busy=0, HI=LO=0; final LO=20, HI=0.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: MDU operation codes and sizing helpers shared by the multiply/divide unit.
package md_pkg;
   localparam int MDUOP_SIZE = 4;
   typedef enum logic [MDUOP_SIZE-1:0] {
      MDUOP_NOOP  = 4'd0,
      MDUOP_MULT  = 4'd1,
      MDUOP_MULTU = 4'd2,
      MDUOP_DIV   = 4'd3,
      MDUOP_DIVU  = 4'd4,
      MDUOP_MTHI  = 4'd5,
      MDUOP_MTLO  = 4'd6,
      MDUOP_MADD  = 4'd7,
      MDUOP_MADDU = 4'd8,
      MDUOP_MSUB  = 4'd9,
      MDUOP_MSUBU = 4'd10
   } mduop_e;
   // Counter only has to hold N-1, so $clog2 of the longest latency suffices (min 1 bit).
   function automatic int cnt_width(input int mul_cycles, input int div_cycles);
      int m;
      m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
      return (m < 2) ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational MDU datapath producing the HI/LO result for a multi-cycle op.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   input  logic [MDUOP_SIZE-1:0] op,
   input  logic [WIDTH-1:0]      hi,
   input  logic [WIDTH-1:0]      lo,
   output logic [WIDTH-1:0]      pend_hi,
   output logic [WIDTH-1:0]      pend_lo,
   output logic                  div_by_zero
);
   logic [2*WIDTH-1:0] acc, sprod, uprod, res;
   logic [WIDTH-1:0] mag_a, mag_b, quo_u, rem_u, quo, rem;
   logic is_div, neg_a, neg_b;
   assign acc = {hi, lo};
   assign sprod = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
   assign uprod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
   assign is_div = (op == MDUOP_DIV) || (op == MDUOP_DIVU);
   assign div_by_zero = is_div && (op_b == '0);
   // Signed divide on magnitudes: -2^(W-1)/-1 falls out as the unsigned 2^(W-1) pattern.
   assign neg_a = (op == MDUOP_DIV) && op_a[WIDTH-1];
   assign neg_b = (op == MDUOP_DIV) && op_b[WIDTH-1];
   assign mag_a = neg_a ? -op_a : op_a;
   assign mag_b = (op_b == '0) ? WIDTH'(1) : (neg_b ? -op_b : op_b);
   assign quo_u = mag_a / mag_b;
   assign rem_u = mag_a % mag_b;
   assign quo = (neg_a ^ neg_b) ? -quo_u : quo_u;
   assign rem = neg_a ? -rem_u : rem_u;
   always_comb begin
      res = (op == MDUOP_MULT)             ? sprod :
            (op == MDUOP_MULTU)            ? uprod :
            (op == MDUOP_MADD)             ? acc + sprod :
            (op == MDUOP_MADDU)            ? acc + uprod :
            (op == MDUOP_MSUB)             ? acc - sprod :
            (op == MDUOP_MSUBU)            ? acc - uprod :
            (is_div && !div_by_zero)       ? {rem, quo} : acc;
   end
   assign {pend_hi, pend_lo} = res;
endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit owning HI/LO, with start/busy for stall control.
module md_unit_param
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      operand1,
   input  logic [WIDTH-1:0]      operand2,
   input  logic [MDUOP_SIZE-1:0] operation,
   input  logic                  cancel,
   output logic [WIDTH-1:0]      HI,
   output logic [WIDTH-1:0]      LO,
   output logic                  start,
   output logic                  busy
);
   localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d, ar_hi, ar_lo;
   logic [CW-1:0] cnt_q, cnt_d;
   logic busy_q, busy_d, dz_q, dz_d, ar_dz, is_mul, is_div, idle_ok, commit;
   md_arith #(.WIDTH(WIDTH)) u_arith (
      .op_a(operand1), .op_b(operand2), .op(operation), .hi(hi_q), .lo(lo_q),
      .pend_hi(ar_hi), .pend_lo(ar_lo), .div_by_zero(ar_dz)
   );
   assign is_mul = operation inside {MDUOP_MULT, MDUOP_MULTU, MDUOP_MADD, MDUOP_MADDU,
                                     MDUOP_MSUB, MDUOP_MSUBU};
   assign is_div = operation inside {MDUOP_DIV, MDUOP_DIVU};
   assign idle_ok = !busy_q && !cancel;
   assign start = (is_mul || is_div) && idle_ok;
   // A zero divisor still occupies the full busy period but commits nothing.
   assign commit = busy_q && (cnt_q == '0) && !dz_q;
   always_comb begin
      hi_d = commit ? phi_q : (idle_ok && operation == MDUOP_MTHI) ? operand1 : hi_q;
      lo_d = commit ? plo_q : (idle_ok && operation == MDUOP_MTLO) ? operand1 : lo_q;
      phi_d = start ? ar_hi : phi_q;
      plo_d = start ? ar_lo : plo_q;
      dz_d = start ? ar_dz : dz_q;
      cnt_d = start ? CW'(is_div ? DIV_CYCLES - 1 : MUL_CYCLES - 1) :
              (busy_q && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      busy_d = start || (busy_q && cnt_q != '0);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         phi_q  <= '0;
         plo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         phi_q  <= phi_d;
         plo_q  <= plo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         dz_q   <= dz_d;
      end
   end
   assign HI = hi_q;
   assign LO = lo_q;
   assign busy = busy_q;
endmodule
